// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_if
// Brief    : Byte-stream handshake plus instruction-memory write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_be;

    // Stream source and memory sink side
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Packs a length-prefixed byte stream into big-endian 32-bit word
//            writes for the instruction memory, holding the CPU off meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int unsigned MEM_BYTES     = 16384,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    instr_mem_loader_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [15:0] r_word_idx;
    logic [31:0] r_lanes;
    logic [3:0]  r_be;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_too_long;
    logic [15:0]              w_len;
    logic [31:0]              w_word;
    logic [3:0]               w_be;
    logic [ADDRESS_WIDTH-1:0] w_word_addr;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_len       = {r_len_hi, bus.in_data};
    assign w_too_long  = 32'(w_len) > MEM_BYTES;
    assign w_last      = (r_cnt == (r_len - 16'd1));
    assign w_word_addr = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'({r_word_idx, 2'b00});

    // Merge the incoming byte into its lane; lane 0 is the lowest address
    always_comb begin
        w_word = r_lanes;
        w_be   = r_be;
        case (r_cnt[1:0])
            2'd0: begin w_word[31:24] = bus.in_data; w_be[3] = 1'b1; end
            2'd1: begin w_word[23:16] = bus.in_data; w_be[2] = 1'b1; end
            2'd2: begin w_word[15:8]  = bus.in_data; w_be[1] = 1'b1; end
            default: begin w_word[7:0] = bus.in_data; w_be[0] = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len_hi      <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_word_idx    <= '0;
            r_lanes       <= '0;
            r_be          <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state      <= S_LEN_HI;
                        r_cnt        <= '0;
                        r_word_idx   <= '0;
                        r_lanes      <= '0;
                        r_be         <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        // Final write pulse has gone out; hand over to the CPU
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= bus.in_data;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
                            r_state      <= S_DONE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else if (w_too_long) begin
                            r_state      <= S_ERR;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            err          <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt[1:0] == 2'd3 || w_last) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= w_word_addr;
                            bus.mem_wdata <= w_word;
                            bus.mem_be    <= w_be;
                            r_word_idx    <= r_word_idx + 16'd1;
                            r_lanes       <= '0;
                            r_be          <= '0;
                        end else begin
                            r_lanes <= w_word;
                            r_be    <= w_be;
                        end
                        if (w_last) begin
                            r_state      <= S_DONE;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Directed self-checking bench for instr_mem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDRESS_WIDTH(32)) bus ();

    instr_mem_loader #(
        .ADDRESS_WIDTH(32),
        .MEM_BYTES    (16384),
        .BASE_ADDR    (0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            q_addr.push_back(bus.mem_addr);
            q_data.push_back(bus.mem_wdata);
            q_be.push_back(bus.mem_be);
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_be.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%02h in_ready=%b required=1", b, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.in_ready, bus.mem_we, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=00000",
                     {bus.in_ready, bus.mem_we, busy, done, err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
            bad++;
            $display("FAIL reset_bus addr=%h wdata=%h be=%h required=0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s  [10] = '{8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [31:0] ea [2]  = '{32'h0, 32'h4};
        logic [31:0] ed [2]  = '{32'hDEADBEEF, 32'h01020304};
        clear_log();
        pulse_start();
        total++;
        if ({busy, bus.in_ready} !== 2'b11) begin
            bad++; $display("FAIL b2b_start busy,in_ready=%b required=11", {busy, bus.in_ready});
        end
        foreach (s[i]) send_byte(s[i]);
        total++;
        if ({bus.mem_we, busy, done} !== 3'b110) begin
            bad++; $display("FAIL b2b_final_pulse we,busy,done=%b required=110", {bus.mem_we, busy, done});
        end
        @(negedge clk);
        total++;
        if ({done, busy, bus.in_ready, bus.mem_we} !== 4'b1000) begin
            bad++; $display("FAIL b2b_done done,busy,in_ready,we=%b required=1000",
                            {done, busy, bus.in_ready, bus.mem_we});
        end
        settle();
        total++;
        if (q_addr.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d required=2", q_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_be[i] !== 4'hF) begin
                    bad++; $display("FAIL b2b_word%0d got=%h/%h/%h required=%h/%h/f",
                                    i, q_addr[i], q_data[i], q_be[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_partial_word();
        logic [7:0]  s  [8] = '{8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [31:0] ea [2] = '{32'h0, 32'h4};
        logic [31:0] ed [2] = '{32'h11223344, 32'h55660000};
        logic [3:0]  eb [2] = '{4'hF, 4'hC};
        clear_log();
        pulse_start();
        total++;
        if ({done, busy, bus.in_ready} !== 3'b011) begin
            bad++; $display("FAIL restart_from_done done,busy,in_ready=%b required=011",
                            {done, busy, bus.in_ready});
        end
        foreach (s[i]) send_byte(s[i]);
        settle();
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL partial_done got=%b required=1", done);
        end
        total++;
        if (q_addr.size() != 2) begin
            bad++; $display("FAIL partial_count got=%0d required=2", q_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_be[i] !== eb[i]) begin
                    bad++; $display("FAIL partial_word%0d got=%h/%h/%h required=%h/%h/%h",
                                    i, q_addr[i], q_data[i], q_be[i], ea[i], ed[i], eb[i]);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if ({done, busy, bus.in_ready, err} !== 4'b1000) begin
            bad++; $display("FAIL zero_len done,busy,in_ready,err=%b required=1000",
                            {done, busy, bus.in_ready, err});
        end
        settle();
        total++;
        if (q_addr.size() != 0) begin
            bad++; $display("FAIL zero_len_writes got=%0d required=0", q_addr.size());
        end
    endtask

    task automatic test_len_error();
        clear_log();
        pulse_start();
        send_byte(8'h40);
        send_byte(8'h01);
        total++;
        if ({err, done, busy, bus.in_ready} !== 4'b1000) begin
            bad++; $display("FAIL len_err err,done,busy,in_ready=%b required=1000",
                            {err, done, busy, bus.in_ready});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        total++;
        if ({err, bus.in_ready, bus.mem_we} !== 3'b100 || q_addr.size() != 0) begin
            bad++; $display("FAIL len_err_hold err,in_ready,we=%b writes=%0d required=100/0",
                            {err, bus.in_ready, bus.mem_we}, q_addr.size());
        end
        bus.in_valid = 1'b0;
        pulse_start();
        total++;
        if ({err, busy, bus.in_ready} !== 3'b011) begin
            bad++; $display("FAIL err_restart err,busy,in_ready=%b required=011",
                            {err, busy, bus.in_ready});
        end
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        settle();
        total++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h0 || q_data[0] !== 32'hA1B2C3D4 || q_be[0] !== 4'hF) begin
            bad++; $display("FAIL err_reload writes=%0d first=%h/%h/%h required=1 0/a1b2c3d4/f",
                            q_addr.size(), q_addr.size() > 0 ? q_addr[0] : 32'hx,
                            q_data.size() > 0 ? q_data[0] : 32'hx, q_be.size() > 0 ? q_be[0] : 4'hx);
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  s   [10] = '{8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        int          gap [10] = '{0, 0, 0, 2, 0, 1, 3, 0, 2, 0};
        logic [31:0] ed  [2]  = '{32'hDEADBEEF, 32'h01020304};
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i]);
            repeat (gap[i]) @(negedge clk);
            if (i == 4) pulse_start();
            if (i == 4) begin
                #1;
                total++;
                if (q_addr.size() != 0) begin
                    bad++; $display("FAIL gaps_early_write got=%0d required=0", q_addr.size());
                end
            end
        end
        settle();
        total++;
        if (q_addr.size() != 2) begin
            bad++; $display("FAIL gaps_count got=%0d required=2", q_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (q_addr[i] !== 32'(4 * i) || q_data[i] !== ed[i] || q_be[i] !== 4'hF) begin
                    bad++; $display("FAIL gaps_word%0d got=%h/%h/%h required=%h/%h/f",
                                    i, q_addr[i], q_data[i], q_be[i], 32'(4 * i), ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s [10] = '{8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(s[i]);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.mem_we, busy, done, err} !== 5'b0 ||
            {bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
            bad++; $display("FAIL mid_reset flags=%b addr=%h wdata=%h be=%h required=0",
                            {bus.in_ready, bus.mem_we, busy, done, err},
                            bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        rst = 1'b0;
        settle();
        total++;
        if (q_addr.size() != 0) begin
            bad++; $display("FAIL mid_reset_writes got=%0d required=0", q_addr.size());
        end
        pulse_start();
        foreach (s[i]) send_byte(s[i]);
        settle();
        total++;
        if (q_addr.size() != 2 || q_addr[0] !== 32'h0 || q_data[0] !== 32'hDEADBEEF ||
            q_addr[1] !== 32'h4 || q_data[1] !== 32'h01020304) begin
            bad++; $display("FAIL mid_reset_reload writes=%0d required=2 words 0:deadbeef 4:01020304",
                            q_addr.size());
        end
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++; $display("FAIL mid_reset_done done,busy=%b required=10", {done, busy});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_word();
        test_zero_length();
        test_len_error();
        test_gaps();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
